// File: rtl/rx_block_lock_descrambler.sv
// rx_block_lock_descrambler: 64b/66b sync-header block lock with gearbox slip requests,
// plus x^58+x^39+1 self-synchronizing descrambler forwarding blocks while locked.
module rx_block_lock_descrambler #(
    parameter int PCS_DATA_WIDTH   = 66,
    parameter int SH_CNT_MAX       = 64,
    parameter int SH_INVLD_MAX     = 16,
    parameter int SLIP_WAIT_BLOCKS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PCS_DATA_WIDTH-1:0] rx_block_in,
    input  logic                      rx_block_valid_in,
    output logic                      slip_out,
    output logic                      block_lock_out,
    output logic [PCS_DATA_WIDTH-1:0] encoded_data_out,
    output logic                      encoded_valid_out
);
    localparam int PW = PCS_DATA_WIDTH - 2;
    typedef enum logic [1:0] {UNLOCKED, SLIP_WAIT, LOCKED} state_t;
    state_t state, state_n;
    logic [6:0] sh_cnt, sh_cnt_n, cnt_inc;
    logic [4:0] sh_invld_cnt, sh_invld_cnt_n, invld_inc;
    logic [57:0] s;
    logic [PW+57:0] ext;
    logic [PW-1:0] payload;
    logic [1:0] hdr;
    logic hdr_ok, slip_n;
    assign hdr = rx_block_in[PCS_DATA_WIDTH-1 -: 2];
    assign hdr_ok = ^hdr;
    assign cnt_inc = sh_cnt + 7'd1;
    assign invld_inc = sh_invld_cnt + {4'b0, ~hdr_ok};
    // ext[58+i] is c[i]; ext[58-k] is the bit k positions before c[0]
    assign ext = {rx_block_in[PW-1:0], s};
    always_comb begin
        payload = '0;
        for (int i = 0; i < PW; i++) payload[i] = ext[58+i] ^ ext[19+i] ^ ext[i];
    end
    always_comb begin
        state_n = state;
        sh_cnt_n = sh_cnt;
        sh_invld_cnt_n = sh_invld_cnt;
        slip_n = 1'b0;
        if (rx_block_valid_in) begin
            sh_cnt_n = cnt_inc;
            case (state)
                UNLOCKED: begin
                    if (!hdr_ok) begin
                        slip_n = 1'b1;
                        state_n = SLIP_WAIT;
                        sh_cnt_n = '0;
                    end else if (cnt_inc == 7'(SH_CNT_MAX)) begin
                        state_n = LOCKED;
                        sh_cnt_n = '0;
                    end
                end
                SLIP_WAIT: begin
                    if (cnt_inc == 7'(SLIP_WAIT_BLOCKS)) begin
                        state_n = UNLOCKED;
                        sh_cnt_n = '0;
                    end
                end
                LOCKED: begin
                    sh_invld_cnt_n = invld_inc;
                    if (invld_inc == 5'(SH_INVLD_MAX)) begin
                        slip_n = 1'b1;
                        state_n = SLIP_WAIT;
                        sh_cnt_n = '0;
                        sh_invld_cnt_n = '0;
                    end else if (cnt_inc == 7'(SH_CNT_MAX)) begin
                        sh_cnt_n = '0;
                        sh_invld_cnt_n = '0;
                    end
                end
                default: state_n = UNLOCKED;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNLOCKED;
            sh_cnt <= '0;
            sh_invld_cnt <= '0;
            s <= '0;
            slip_out <= 1'b0;
            block_lock_out <= 1'b0;
            encoded_data_out <= '0;
            encoded_valid_out <= 1'b0;
        end else begin
            state <= state_n;
            sh_cnt <= sh_cnt_n;
            sh_invld_cnt <= sh_invld_cnt_n;
            slip_out <= slip_n;
            block_lock_out <= state_n == LOCKED;
            encoded_valid_out <= rx_block_valid_in && state == LOCKED;
            if (rx_block_valid_in) begin
                s <= rx_block_in[PW-1:PW-58];
                if (state == LOCKED) encoded_data_out <= {hdr, payload};
            end
        end
    end
endmodule

// File: tb/tb_rx_block_lock_descrambler.sv
// tb_rx_block_lock_descrambler: directed scoreboard bench for block lock, slip, hysteresis,
// descrambling with idle gaps, and reset recovery.
module tb_rx_block_lock_descrambler;
    localparam logic [63:0] BASE = 64'h0123456789ABCDEF;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [65:0] rx_block_in = '0;
    logic rx_block_valid_in = 1'b0;
    logic slip_out, block_lock_out, encoded_valid_out;
    logic [65:0] encoded_data_out;
    logic [57:0] sr = '0;
    logic [65:0] exp_q[$];
    logic [65:0] last_fwd = '0;
    int n_chk = 0;
    int n_fail = 0;
    int k = 0;

    always #5 clk = ~clk;

    rx_block_lock_descrambler dut (
        .clk(clk),
        .rst(rst),
        .rx_block_in(rx_block_in),
        .rx_block_valid_in(rx_block_valid_in),
        .slip_out(slip_out),
        .block_lock_out(block_lock_out),
        .encoded_data_out(encoded_data_out),
        .encoded_valid_out(encoded_valid_out)
    );

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // serial golden scrambler: sr[0] is the most recent scrambled bit
    function automatic logic [63:0] scramble(input logic [63:0] d);
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c[i] = d[i] ^ sr[38] ^ sr[57];
            sr = {sr[56:0], c[i]};
        end
        return c;
    endfunction

    task automatic blk(input logic [1:0] hdr, input logic fwd, input logic slip_e,
                       input logic lock_e, input string tag);
        logic [63:0] d;
        d = BASE + 64'(k);
        k++;
        rx_block_in = {hdr, scramble(d)};
        rx_block_valid_in = 1'b1;
        if (fwd) begin
            exp_q.push_back({hdr, d});
            last_fwd = {hdr, d};
        end
        @(posedge clk);
        #1;
        rx_block_valid_in = 1'b0;
        chk({tag, " slip"}, 66'(slip_out), 66'(slip_e));
        chk({tag, " lock"}, 66'(block_lock_out), 66'(lock_e));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            rx_block_in = {2'($urandom), $urandom, $urandom};
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (encoded_valid_out) begin
                    if (exp_q.size() == 0) chk("unexpected block", 66'(encoded_valid_out), 66'(0));
                    else chk("block data", encoded_data_out, exp_q.pop_front());
                end
            end
        join_none
        for (int i = 0; i < 3; i++) begin
            rx_block_in = {2'($urandom), $urandom, $urandom};
            rx_block_valid_in = 1'b1;
            @(posedge clk);
            #1;
            chk("reset slip", 66'(slip_out), 66'(0));
            chk("reset lock", 66'(block_lock_out), 66'(0));
            chk("reset valid", 66'(encoded_valid_out), 66'(0));
            chk("reset data", encoded_data_out, 66'(0));
        end
        rx_block_valid_in = 1'b0;
        rst = 1'b0;
        for (int j = 0; j < 64; j++) blk(2'b01, 1'b0, 1'b0, j == 63, "acq");
        for (int j = 0; j < 64; j++)
            blk((j % 4 == 1 && j < 60) ? 2'b11 : 2'b01, 1'b1, 1'b0, 1'b1, "win15");
        for (int j = 0; j < 64; j++) begin
            if ((j % 4 == 3 && j < 60) || j == 63)
                blk((j % 8 == 3) ? 2'b00 : 2'b11, 1'b1, j == 63, j < 63, "win16");
            else
                blk(2'b01, 1'b1, 1'b0, 1'b1, "win16");
        end
        for (int j = 0; j < 8; j++) blk(j == 2 ? 2'b00 : 2'b01, 1'b0, 1'b0, 1'b0, "slipwait");
        for (int j = 0; j < 9; j++) blk(2'b01, 1'b0, 1'b0, 1'b0, "pre");
        blk(2'b11, 1'b0, 1'b1, 1'b0, "slip10");
        for (int j = 0; j < 8; j++) blk(j == 5 ? 2'b11 : 2'b10, 1'b0, 1'b0, 1'b0, "wait");
        for (int j = 0; j < 64; j++) blk(2'b01, 1'b0, 1'b0, j == 63, "reacq");
        for (int j = 0; j < 4; j++) begin
            idle(3);
            blk(j[0] ? 2'b10 : 2'b01, 1'b1, 1'b0, 1'b1, "gap");
        end
        idle(2);
        chk("hold data", encoded_data_out, last_fwd);
        chk("idle valid", 66'(encoded_valid_out), 66'(0));
        rx_block_in = {2'b01, scramble(BASE + 64'(k))};
        k++;
        rx_block_valid_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_block_valid_in = 1'b0;
        chk("midrst lock", 66'(block_lock_out), 66'(0));
        chk("midrst slip", 66'(slip_out), 66'(0));
        chk("midrst valid", 66'(encoded_valid_out), 66'(0));
        chk("midrst data", encoded_data_out, 66'(0));
        sr = 58'({$urandom, $urandom});
        for (int j = 0; j < 64; j++) blk(2'b01, 1'b0, 1'b0, j == 63, "seed acq");
        for (int j = 0; j < 6; j++) begin
            blk(2'b01, 1'b1, 1'b0, 1'b1, "seed fwd");
            idle(j % 3);
        end
        idle(3);
        chk("queue drained", 66'(exp_q.size()), 66'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
